// File: rtl/sized_data_memory_pkg.sv
// Shared types and the alignment rule for the sized data memory.
package mem_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeRsvd = 2'd3
    } mem_size_e;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } mem_state_e;

    // Reserved size is treated as a fault regardless of address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        case (size)
            SizeByte: bad = 1'b0;
            SizeHalf: bad = addr[0];
            SizeWord: bad = (addr != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sized_data_memory_load_extend.sv
// Selects the addressed byte/half of a little-endian word, right-aligns it and
// sign- or zero-extends it to 32 bits.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    assign byte_sel  = word[{lane, 3'b000} +: 8];
    assign half_sel  = word[{lane[1], 4'b0000} +: 16];
    assign byte_sign = ~is_unsigned & byte_sel[7];
    assign half_sign = ~is_unsigned & half_sel[15];

    always_comb begin
        value = word;
        case (size)
            SizeByte: value = {{24{byte_sign}}, byte_sel};
            SizeHalf: value = {{16{half_sign}}, half_sel};
            default:  value = word;
        endcase
    end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with sized, extended loads, lane-masked stores,
// misalignment faults and a post-reset zeroing sweep.
module sized_data_memory
    import mem_pkg::*;
#(
    parameter int  Depth        = 64,
    parameter bit  ClearOnReset = 1'b1,
    localparam int AddrWidth    = $clog2(Depth) + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 memory_read,
    input  logic                 memory_write,
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    input  logic [AddrWidth-1:0] address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 read_valid,
    output logic                 fault,
    output logic                 ready
);

    localparam int IdxWidth = AddrWidth - 2;

    logic [31:0]         mem [Depth];

    mem_state_e          state_reg;
    logic [IdxWidth-1:0] counter_reg;
    logic                ready_reg;
    logic [31:0]         read_data_reg;
    logic                read_valid_reg;
    logic                fault_reg;

    logic [IdxWidth-1:0] word_idx;
    logic [1:0]          lane;
    logic                accept;
    logic                bad;
    logic                do_write;
    logic [3:0]          lane_we;
    logic [31:0]         lane_wdata;
    logic [31:0]         raw_word;
    logic [31:0]         ext_value;

    assign word_idx = address[AddrWidth-1:2];
    assign lane     = address[1:0];
    assign bad      = is_misaligned(size, lane);
    assign accept   = ready_reg & (state_reg == StRun) & (memory_read | memory_write);
    assign do_write = accept & memory_write & ~bad;

    // Narrow store data is replicated so every enabled lane sees its own byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LaneId = 2'(gi);

        assign lane_we[gi] = (size == SizeWord)
                           | ((size == SizeHalf) & (lane[1] == LaneId[1]))
                           | ((size == SizeByte) & (lane == LaneId));

        assign lane_wdata[gi*8 +: 8] = (size == SizeByte) ? write_data[7:0] :
                                       (size == SizeHalf) ? write_data[(gi % 2)*8 +: 8] :
                                                            write_data[gi*8 +: 8];
    end

    // Storage has no reset; the INIT sweep is the only thing that defines it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_reg == StInit) begin
                mem[counter_reg] <= '0;
            end else if (do_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_we[i]) begin
                        mem[word_idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

    // Combinational read ahead of the edge gives read-first on collisions.
    assign raw_word = mem[word_idx];

    load_extend u_load_extend (
        .word        (raw_word),
        .lane        (lane),
        .size        (size),
        .is_unsigned (is_unsigned),
        .value       (ext_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ClearOnReset ? StInit : StRun;
            counter_reg    <= '0;
            ready_reg      <= 1'b0;
            read_data_reg  <= '0;
            read_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            read_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
            if (state_reg == StInit) begin
                counter_reg <= counter_reg + 1'b1;
                if (counter_reg == IdxWidth'(Depth - 1)) begin
                    state_reg <= StRun;
                    ready_reg <= 1'b1;
                end
            end else begin
                ready_reg <= 1'b1;
                if (accept) begin
                    if (bad) begin
                        fault_reg <= 1'b1;
                    end else if (memory_read) begin
                        read_data_reg  <= ext_value;
                        read_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign read_data  = read_data_reg;
    assign read_valid = read_valid_reg;
    assign fault      = fault_reg;
    assign ready      = ready_reg;

endmodule

// File: tb/tb_sized_data_memory.sv
// Directed scoreboard bench: stimulus queues expected responses, a monitor on
// the falling edge pops and compares whenever the memory reports a result.
module tb_sized_data_memory;

    localparam int Depth     = 64;
    localparam int AddrWidth = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 memory_read = 1'b0;
    logic                 memory_write = 1'b0;
    logic [1:0]           size = 2'd0;
    logic                 is_unsigned = 1'b0;
    logic [AddrWidth-1:0] address = '0;
    logic [31:0]          write_data = '0;
    logic [31:0]          read_data;
    logic                 read_valid;
    logic                 fault;
    logic                 ready;

    sized_data_memory #(
        .Depth        (Depth),
        .ClearOnReset (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memory_read  (memory_read),
        .memory_write (memory_write),
        .size         (size),
        .is_unsigned  (is_unsigned),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .fault        (fault),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fault;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every reported response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (read_valid || fault)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_response: got valid=%0b fault=%0b, expected none",
                         read_valid, fault);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_flags"}, {30'd0, fault, read_valid},
                      {30'd0, mon_e.is_fault, ~mon_e.is_fault});
                if (!mon_e.is_fault)
                    check(mon_e.name, read_data, mon_e.data);
                $display("[TB] %s: valid=%0b fault=%0b data=0x%08h",
                         mon_e.name, read_valid, fault, read_data);
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [7:0] a, input logic [31:0] wd,
                          input bit exp_fault, input logic [31:0] exp_data, input string name);
        exp_t e;
        @(negedge clk);
        memory_read  = rd;
        memory_write = wr;
        size         = sz;
        is_unsigned  = uns;
        address      = a;
        write_data   = wd;
        e.is_fault   = exp_fault;
        e.data       = exp_data;
        e.name       = name;
        if (exp_fault || rd)
            sb.push_back(e);
    endtask

    task automatic load(input logic [1:0] sz, input bit uns, input logic [7:0] a,
                        input logic [31:0] exp, input string name);
        access(1'b1, 1'b0, sz, uns, a, 32'h0, 1'b0, exp, name);
    endtask

    task automatic store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        access(1'b0, 1'b1, sz, 1'b0, a, wd, 1'b0, 32'h0, "store");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            memory_read  = 1'b0;
            memory_write = 1'b0;
        end
    endtask

    // Called right after rst_n rises on a falling edge: ready must rise on edge Depth.
    task automatic clear_check(input string name);
        for (int i = 1; i <= Depth; i++) begin
            @(negedge clk);
            check($sformatf("%s_ready_c%0d", name, i), {31'd0, ready}, {31'd0, (i == Depth)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_read_valid", {31'd0, read_valid}, 32'h0);
        check("rst_fault", {31'd0, fault}, 32'h0);
        check("rst_ready", {31'd0, ready}, 32'h0);
        rst_n = 1'b1;
        clear_check("clear1");

        load(2'd2, 1'b0, 8'h00, 32'h0000_0000, "cleared_w00");
        load(2'd2, 1'b0, 8'hFC, 32'h0000_0000, "cleared_wFC");

        store(2'd2, 8'h10, 32'h1122_3344);
        store(2'd0, 8'h12, 32'hDEAD_BEAA);
        load(2'd2, 1'b0, 8'h10, 32'h11AA_3344, "lane_merge_w10");
        load(2'd0, 1'b0, 8'h12, 32'hFFFF_FFAA, "byte_s_12");
        load(2'd0, 1'b1, 8'h12, 32'h0000_00AA, "byte_u_12");
        load(2'd1, 1'b0, 8'h12, 32'h0000_11AA, "half_s_12");
        load(2'd1, 1'b0, 8'h10, 32'h0000_3344, "half_s_10");
        load(2'd0, 1'b1, 8'h13, 32'h0000_0011, "byte_u_13");
        idle(2);
        check("hold_read_data", read_data, 32'h0000_0011);

        access(1'b0, 1'b1, 2'd2, 1'b0, 8'h11, 32'hFFFF_FFFF, 1'b1, 32'h0, "fault_w11");
        access(1'b1, 1'b0, 2'd1, 1'b0, 8'h13, 32'h0, 1'b1, 32'h0, "fault_h13");
        access(1'b1, 1'b0, 2'd3, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0, "fault_rsvd");
        idle(2);
        check("fault_keeps_read_data", read_data, 32'h0000_0011);
        load(2'd2, 1'b0, 8'h10, 32'h11AA_3344, "after_fault_w10");

        store(2'd2, 8'h20, 32'h0000_0005);
        access(1'b1, 1'b1, 2'd2, 1'b0, 8'h20, 32'h0000_0009, 1'b0, 32'h0000_0005, "collide_w20");
        load(2'd2, 1'b0, 8'h20, 32'h0000_0009, "post_collide_w20");

        store(2'd1, 8'h22, 32'h0000_8001);
        load(2'd1, 1'b0, 8'h22, 32'hFFFF_8001, "half_s_22");
        load(2'd0, 1'b1, 8'h20, 32'h0000_0009, "byte_u_20");

        store(2'd2, 8'h30, 32'h0000_0077);
        load(2'd2, 1'b0, 8'h30, 32'h0000_0077, "w30");
        idle(2);

        // Reset in RUN right after a load has been sampled.
        @(negedge clk);
        memory_read = 1'b1;
        size        = 2'd2;
        address     = 8'h30;
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        memory_read = 1'b0;
        #1;
        check("run_rst_read_valid", {31'd0, read_valid}, 32'h0);
        check("run_rst_read_data", read_data, 32'h0);
        check("run_rst_ready", {31'd0, ready}, 32'h0);

        // Reset again partway through the clear sweep.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("init_rst_ready", {31'd0, ready}, 32'h0);
        check("init_rst_read_data", read_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_check("clear2");

        load(2'd2, 1'b0, 8'h30, 32'h0000_0000, "recleared_w30");
        load(2'd2, 1'b0, 8'h10, 32'h0000_0000, "recleared_w10");
        idle(2);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
